barrel_shift_pipe: RTL and testbench

BARREL_SHIFT_PIPE -- requirements
Module: barrel_shift_pipe

---
 rtl/barrel_shift_pipe.sv | 127 ++++++++++++
 tb/tb_barrel_shift_pipe.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shift_pipe.sv
// Two-stage pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready handshake.
// Stage 1 applies the low amount bits, stage 2 the remaining high bits plus saturation.
module barrel_shift_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam int SHW  = $clog2(WIDTH);
  localparam int LOWB = SHW / 2;
  localparam int HIB  = SHW - LOWB;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // Shared shifter for both stages; SRA fills from the captured sign, not d's MSB.
  function automatic logic [WIDTH-1:0] shift_op(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input logic [SHW-1:0]   amt,
    input logic             sign
  );
    logic [2*WIDTH-1:0] rot;
    logic [WIDTH-1:0]   fill;
    logic [WIDTH-1:0]   res;
    rot  = {d, d} >> amt;
    fill = ~({WIDTH{1'b1}} >> amt);
    case (op)
      OP_SLL:  res = d << amt;
      OP_SRL:  res = d >> amt;
      OP_SRA:  res = (d >> amt) | (sign ? fill : '0);
      default: res = rot[WIDTH-1:0];
    endcase
    return res;
  endfunction

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [1:0]       s1_op;
  logic [HIB-1:0]   s1_hi;
  logic             s1_sign;
  logic             s1_sat;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_data;
  logic             s2_zero;

  logic             s1_adv;
  logic             s2_adv;
  logic [SHW-1:0]   amt_lo;
  logic [SHW-1:0]   amt_hi;
  logic [WIDTH-1:0] s1_next;
  logic [WIDTH-1:0] s2_shift;
  logic [WIDTH-1:0] s2_next;
  logic             in_sat;

  assign s2_adv   = ~s2_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = rst_n & s1_adv & ~flush;

  assign amt_lo  = {{HIB{1'b0}}, in_amt[LOWB-1:0]};
  assign in_sat  = |in_amt[31:SHW];
  assign s1_next = shift_op(in_data, in_op, amt_lo, in_data[WIDTH-1]);

  assign amt_hi   = {s1_hi, {LOWB{1'b0}}};
  assign s2_shift = shift_op(s1_data, s1_op, amt_hi, s1_sign);

  // Oversized amounts saturate the linear shifts; rotate only uses amt mod WIDTH.
  always_comb begin
    s2_next = s2_shift;
    if (s1_sat && (s1_op != OP_ROR)) begin
      s2_next = (s1_op == OP_SRA && s1_sign) ? {WIDTH{1'b1}} : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_adv) s2_valid <= s1_valid;
      if (s1_adv) s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_data <= s1_next;
      s1_op   <= in_op;
      s1_hi   <= in_amt[SHW-1:LOWB];
      s1_sign <= in_data[WIDTH-1];
      s1_sat  <= in_sat;
    end
  end

  // Output data is reset so that out_data reads zero while held in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_data <= '0;
      s2_zero <= 1'b0;
    end else if (s2_adv && s1_valid) begin
      s2_data <= s2_next;
      s2_zero <= (s2_next == '0);
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_zero  = s2_valid & s2_zero;

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Directed bench for barrel_shift_pipe: vector table plus backpressure, flush and reset sequences.
module tb_barrel_shift_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_op;
  logic [31:0] in_amt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_zero;

  int n_vec;
  int n_err;

  barrel_shift_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_op(in_op), .in_amt(in_amt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [31:0] amt;
    logic [31:0] exp;
  } vec_t;

  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] SRA = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] d, input logic [31:0] a);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_amt   = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    vecs[0]  = '{SRL, 32'h0F0F0F0F, 32'd13,         32'h00007878};
    vecs[1]  = '{SLL, 32'h0F0F0F0F, 32'd27,         32'h78000000};
    vecs[2]  = '{SRL, 32'h0F0F0F0F, 32'd34,         32'h00000000};
    vecs[3]  = '{SRA, 32'h80000000, 32'd4,          32'hF8000000};
    vecs[4]  = '{SRA, 32'h80000000, 32'd40,         32'hFFFFFFFF};
    vecs[5]  = '{ROR, 32'h0F0F0F0F, 32'd36,         32'hF0F0F0F0};
    vecs[6]  = '{ROR, 32'h12345678, 32'd0,          32'h12345678};
    vecs[7]  = '{SLL, 32'h12345678, 32'd0,          32'h12345678};
    vecs[8]  = '{SRL, 32'h12345678, 32'd0,          32'h12345678};
    vecs[9]  = '{SRA, 32'h80000001, 32'd0,          32'h80000001};
    vecs[10] = '{SLL, 32'h00000001, 32'd31,         32'h80000000};
    vecs[11] = '{SLL, 32'h00000001, 32'd32,         32'h00000000};
    vecs[12] = '{SRA, 32'h7FFFFFFF, 32'd100,        32'h00000000};
    vecs[13] = '{SRA, 32'hF0000000, 32'd31,         32'hFFFFFFFF};
    vecs[14] = '{ROR, 32'h00000001, 32'd1,          32'h80000000};
    vecs[15] = '{ROR, 32'h12345678, 32'hFFFFFFE8,   32'h78123456};
    vecs[16] = '{SRL, 32'h80000000, 32'd31,         32'h00000001};
    vecs[17] = '{SLL, 32'hFFFFFFFF, 32'h00000100,   32'h00000000};
    vecs[18] = '{SRA, 32'h40000000, 32'd3,          32'h08000000};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00;
    in_data = '0; in_amt = '0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_out_data",  out_data,           32'd0);
    chk("rst_out_zero",  {31'd0, out_zero},  32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Table: one request at a time, result two edges after acceptance.
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].op, vecs[i].data, vecs[i].amt);
      tick();
      in_valid = 1'b0;
      tick();
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_data", i),  out_data, vecs[i].exp);
      chk($sformatf("vec%0d_zero", i),  {31'd0, out_zero}, {31'd0, vecs[i].exp == 32'd0});
    end
    tick();
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);

    // Back-to-back: one result per cycle.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(vecs[i].op, vecs[i].data, vecs[i].amt);
      else in_valid = 1'b0;
      tick();
      if (i >= 1) begin
        chk($sformatf("tput%0d_valid", i), {31'd0, out_valid}, 32'd1);
        chk($sformatf("tput%0d_data", i),  out_data, vecs[i-1].exp);
      end
    end
    tick();
    chk("tput_drain", {31'd0, out_valid}, 32'd0);

    // Backpressure: A, B accepted, C held off, then A, B, C in order.
    out_ready = 1'b0;
    drive(SLL, 32'h00000001, 32'd4);
    chk("bp_ready_a", {31'd0, in_ready}, 32'd1);
    tick();
    drive(SRL, 32'h00000100, 32'd8);
    chk("bp_ready_b", {31'd0, in_ready}, 32'd1);
    tick();
    drive(ROR, 32'h00000001, 32'd4);
    chk("bp_ready_c", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_a0", out_data, 32'h00000010);
    tick();
    chk("bp_ready_c2", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_hold_a1", out_data, 32'h00000010);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_out_a", out_data, 32'h00000010);
    tick();
    in_valid = 1'b0;
    chk("bp_out_b", out_data, 32'h00000001);
    tick();
    chk("bp_out_c_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_out_c", out_data, 32'h10000000);
    tick();
    chk("bp_drain", {31'd0, out_valid}, 32'd0);

    // Flush with two in flight and a concurrent request.
    drive(SLL, 32'h00000003, 32'd1);
    tick();
    drive(SLL, 32'h00000005, 32'd1);
    tick();
    chk("fl_pre_valid", {31'd0, out_valid}, 32'd1);
    drive(SLL, 32'h00000007, 32'd1);
    flush = 1'b1;
    #1;
    chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid0", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("fl_stale%0d", i), {31'd0, out_valid}, 32'd0);
    end

    // Asynchronous reset between edges with the pipeline full.
    out_ready = 1'b0;
    drive(SRL, 32'hFFFF0000, 32'd16);
    tick();
    drive(SRL, 32'hFFFF0000, 32'd8);
    tick();
    in_valid = 1'b0;
    chk("ar_full_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_in_ready",  {31'd0, in_ready},  32'd0);
    chk("ar_out_data",  out_data,           32'd0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("ar_post_ready", {31'd0, in_ready}, 32'd1);
    chk("ar_post_valid0", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("ar_stale%0d", i), {31'd0, out_valid}, 32'd0);
    end

    drive(SRA, 32'h80000000, 32'd4);
    tick();
    in_valid = 1'b0;
    tick();
    chk("final_valid", {31'd0, out_valid}, 32'd1);
    chk("final_data", out_data, 32'hF8000000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
